// File: rtl/mdu_pkg.sv
// Shared encodings, sizes and negation helpers for the iterative multiply/divide unit.
package mdu_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_t;

    function automatic logic [WIDTH-1:0] neg32(input logic [WIDTH-1:0] x);
        return WIDTH'(~x + WIDTH'(1));
    endfunction

    function automatic logic [2*WIDTH-1:0] neg64(input logic [2*WIDTH-1:0] x);
        return (2*WIDTH)'(~x + (2*WIDTH)'(1));
    endfunction

endpackage

// File: rtl/mdu_addsub_32.sv
// 32-bit ripple-carry adder and the add/subtract wrapper the multiply/divide unit iterates on.
module Add_rca_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        c_in,
    output logic [31:0] sum,
    output logic        c_out
);
    always_comb begin
        logic carry;
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < 32; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

module mdu_addsub_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    output logic [31:0] sum,
    output logic        c_out
);
    // Subtract as a + ~b + 1; c_out=1 then means no borrow.
    Add_rca_32 u_rca (
        .a     (a),
        .b     (b ^ {32{sub}}),
        .c_in  (sub),
        .sum   (sum),
        .c_out (c_out)
    );
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers: shift-add multiply, restoring divide.
module mult_div_unit
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    state_t             state, state_next;
    op_t                op_r;
    logic [WIDTH-1:0]   p, q, m;
    logic [CNT_W-1:0]   cnt;
    logic               neg_q, neg_r;

    logic [WIDTH-1:0]   add_a, add_b, add_sum;
    logic               add_sub, add_c;
    logic               in_signed;
    logic [WIDTH-1:0]   rs_mag, rt_mag;

    assign in_signed = ~op[0];
    assign rs_mag    = (in_signed && rs[WIDTH-1]) ? neg32(rs) : rs;
    assign rt_mag    = (in_signed && rt[WIDTH-1]) ? neg32(rt) : rt;

    // Multiply: P + (Q[0] ? M : 0). Divide: shifted R minus divisor.
    always_comb begin
        add_a   = p;
        add_b   = q[0] ? m : '0;
        add_sub = 1'b0;
        if (op_r[1]) begin
            add_a   = {p[WIDTH-2:0], q[WIDTH-1]};
            add_b   = m;
            add_sub = 1'b1;
        end
    end

    mdu_addsub_32 u_addsub (
        .a     (add_a),
        .b     (add_b),
        .sub   (add_sub),
        .sum   (add_sum),
        .c_out (add_c)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = ST_RUN;
            ST_RUN:  if (cnt == CNT_W'(ITER - 1)) state_next = ST_FIX;
            ST_FIX:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_r  <= OP_MULT;
            p     <= '0;
            q     <= '0;
            m     <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_r  <= op_t'(op);
                        p     <= '0;
                        q     <= op[1] ? rs_mag : rt_mag;
                        m     <= op[1] ? rt_mag : rs_mag;
                        cnt   <= '0;
                        // Zero divisor keeps an unsigned all-ones quotient; remainder fix restores raw rs.
                        neg_q <= in_signed && (rs[WIDTH-1] ^ rt[WIDTH-1]) && (rt != '0);
                        neg_r <= in_signed && rs[WIDTH-1];
                        busy  <= 1'b1;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op_r[1]) begin
                        p <= add_c ? add_sum : add_a;
                        q <= {q[WIDTH-2:0], add_c};
                    end else begin
                        p <= {add_c, add_sum[WIDTH-1:1]};
                        q <= {add_sum[0], q[WIDTH-1:1]};
                    end
                end
                ST_FIX: begin
                    if (op_r[1]) begin
                        hi <= neg_r ? neg32(p) : p;
                        lo <= neg_q ? neg32(q) : q;
                    end else if (neg_q) begin
                        {hi, lo} <= neg64({p, q});
                    end else begin
                        {hi, lo} <= {p, q};
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
